// File: rtl/scroll_pkg.sv
// Shared constants and mode encoding for the scrolling-text display control path.
package scroll_pkg;

  localparam int unsigned CLK50_HZ         = 50_000_000;
  localparam int unsigned FAST_DIV_DEF     = CLK50_HZ;
  localparam int unsigned SLOW_MULT_DEF    = 4;
  localparam int unsigned DEBOUNCE_CYC_DEF = CLK50_HZ / 50;

  typedef enum logic {
    MODE_FAST = 1'b0,
    MODE_SLOW = 1'b1
  } mode_e;

  // Counter width for a modulus n, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/scroll_tick_gen_key_debounce.sv
// One pushbutton: synchroniser, level debouncer and registered press pulse.
module key_debounce
  import scroll_pkg::*;
#(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
  input  logic clk,
  input  logic clr_n,
  input  logic key,
  output logic rise,
  output logic evt
);

  localparam int unsigned     CW       = cnt_width(DEBOUNCE_CYC);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   sample;
  logic                   level;
  logic                   level_q;
  logic [CW-1:0]          cnt;

  assign sample = sync[SYNC_STAGES-1];
  // High for the one cycle after the debounced level has gone 0->1.
  assign rise   = level & ~level_q;

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      sync    <= '0;
      level   <= 1'b0;
      level_q <= 1'b0;
      cnt     <= '0;
      evt     <= 1'b0;
    end else begin
      sync    <= {sync[SYNC_STAGES-2:0], key};
      level_q <= level;
      evt     <= rise;
      if (sample == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/scroll_tick_gen.sv
// Scroll-rate control: debounced mode keys, fast/slow prescaler, one-cycle advance strobe.
module scroll_tick_gen
  import scroll_pkg::*;
#(
  parameter int unsigned FAST_DIV     = FAST_DIV_DEF,
  parameter int unsigned SLOW_MULT    = SLOW_MULT_DEF,
  parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic clk50,
  input  logic clr_n,
  input  logic key0,
  input  logic key1,
  output logic tick,
  output logic slow,
  output logic key0_evt,
  output logic key1_evt
);

  localparam int unsigned   PW        = cnt_width(FAST_DIV);
  localparam int unsigned   SW        = cnt_width(SLOW_MULT);
  localparam logic [PW-1:0] PCNT_LAST = PW'(FAST_DIV - 1);
  localparam logic [SW-1:0] SCNT_LAST = SW'(SLOW_MULT - 1);

  mode_e         mode;
  mode_e         mode_next;
  logic [PW-1:0] pcnt;
  logic [PW-1:0] pcnt_next;
  logic [SW-1:0] scnt;
  logic [SW-1:0] scnt_next;
  logic          tick_next;
  logic          pwrap;
  logic          mode_chg;
  logic          rise0;
  logic          rise1;

  key_debounce #(
    .SYNC_STAGES (SYNC_STAGES),
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_key0 (
    .clk  (clk50),
    .clr_n(clr_n),
    .key  (key0),
    .rise (rise0),
    .evt  (key0_evt)
  );

  key_debounce #(
    .SYNC_STAGES (SYNC_STAGES),
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_key1 (
    .clk  (clk50),
    .clr_n(clr_n),
    .key  (key1),
    .rise (rise1),
    .evt  (key1_evt)
  );

  always_ff @(posedge clk50) begin
    if (!clr_n) begin
      mode <= MODE_FAST;
      pcnt <= '0;
      scnt <= '0;
      tick <= 1'b0;
    end else begin
      mode <= mode_next;
      pcnt <= pcnt_next;
      scnt <= scnt_next;
      tick <= tick_next;
    end
  end

  always_comb begin
    mode_next = mode;
    if (rise0) begin
      mode_next = MODE_FAST;
    end else if (rise1) begin
      mode_next = MODE_SLOW;
    end
    mode_chg = (mode_next != mode);

    pwrap     = (pcnt == PCNT_LAST);
    pcnt_next = pwrap ? '0 : pcnt + PW'(1);
    scnt_next = scnt;
    if (pwrap) begin
      scnt_next = (scnt == SCNT_LAST) ? '0 : scnt + SW'(1);
    end
    tick_next = pwrap && ((mode == MODE_FAST) || (scnt == SCNT_LAST));

    // A real mode change restarts the period and swallows any coincident tick.
    if (mode_chg) begin
      pcnt_next = '0;
      scnt_next = '0;
      tick_next = 1'b0;
    end
  end

  assign slow = (mode == MODE_SLOW);

endmodule

// File: tb/tb_scroll_tick_gen.sv
// Self-checking bench for scroll_tick_gen with a cycle-indexed behavioural reference model.
module tb_scroll_tick_gen;

  localparam int FD   = 10;
  localparam int SM   = 4;
  localparam int DB   = 8;
  localparam int SS   = 2;
  localparam int MAXC = 8192;

  logic clk = 1'b0;
  logic clr_n = 1'b0;
  logic key0 = 1'b0;
  logic key1 = 1'b0;
  logic tick, slow, key0_evt, key1_evt;

  int checks = 0;
  int failures = 0;

  logic [3:0] obs, expv;

  scroll_tick_gen #(
    .FAST_DIV    (FD),
    .SLOW_MULT   (SM),
    .DEBOUNCE_CYC(DB),
    .SYNC_STAGES (SS)
  ) dut (
    .clk50   (clk),
    .clr_n   (clr_n),
    .key0    (key0),
    .key1    (key1),
    .tick    (tick),
    .slow    (slow),
    .key0_evt(key0_evt),
    .key1_evt(key1_evt)
  );

  always #5 clk = ~clk;

  // Reference model: raw key history indexed by edge number, debounced levels
  // judged over a window of synchronised samples, ticks from the phase origin.
  bit   raw0 [MAXC];
  bit   raw1 [MAXC];
  int   cyc = 0;
  int   last_reset = 0;
  int   last_flip0 = 0;
  int   last_flip1 = 0;
  int   origin = 0;
  int   per;
  bit   lvl0 = 0, lvl1 = 0, pend0 = 0, pend1 = 0, mmode = 0, nm;
  logic exp_tick = 0, exp_slow = 0, exp_e0 = 0, exp_e1 = 0;

  function automatic bit samp(input bit k, input int e);
    if (e - SS <= last_reset || e - SS < 0) return 1'b0;
    return k ? raw1[e-SS] : raw0[e-SS];
  endfunction

  function automatic bit should_flip(input bit k, input bit lv, input int lf);
    int base;
    base = (lf > last_reset) ? lf : last_reset;
    if (cyc - base < DB) return 1'b0;
    for (int j = 0; j < DB; j++)
      if (samp(k, cyc - j) == lv) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (cyc >= MAXC - 1) begin
      $display("FAIL model_budget got=%0d exp=<%0d", cyc, MAXC - 1);
      $fatal(1, "cycle budget exhausted");
    end
    raw0[cyc] = key0;
    raw1[cyc] = key1;
    if (!clr_n) begin
      last_reset = cyc;
      lvl0 = 0; lvl1 = 0; pend0 = 0; pend1 = 0; mmode = 0; origin = cyc;
      exp_tick = 0; exp_slow = 0; exp_e0 = 0; exp_e1 = 0;
    end else begin
      exp_e0 = pend0;
      exp_e1 = pend1;
      nm = pend0 ? 1'b0 : (pend1 ? 1'b1 : mmode);
      if (nm != mmode) begin
        mmode  = nm;
        origin = cyc;
      end
      per      = mmode ? FD * SM : FD;
      exp_tick = (cyc != origin) && ((cyc - origin) % per == 0);
      exp_slow = mmode;
      pend0 = 0;
      pend1 = 0;
      if (should_flip(1'b0, lvl0, last_flip0)) begin
        lvl0 = !lvl0; last_flip0 = cyc; pend0 = lvl0;
      end
      if (should_flip(1'b1, lvl1, last_flip1)) begin
        lvl1 = !lvl1; last_flip1 = cyc; pend1 = lvl1;
      end
    end
  end

  task automatic test_reset();
    int first_t = 0, second_t = 0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      obs = {tick, slow, key0_evt, key1_evt};
      checks++;
      if (obs !== 4'b0000) begin
        failures++; $display("FAIL reset_outputs cyc=%0d got=%b exp=0000", i, obs);
      end
    end
    clr_n = 1'b1;
    for (int i = 1; i <= 35; i++) begin
      @(negedge clk);
      obs = {tick, slow, key0_evt, key1_evt};
      expv = {exp_tick, exp_slow, exp_e0, exp_e1};
      checks++;
      if (obs !== expv) begin
        failures++; $display("FAIL reset_model cyc=%0d got=%b exp=%b", i, obs, expv);
      end
      if (tick === 1'b1 && first_t != 0 && second_t == 0) second_t = i;
      if (tick === 1'b1 && first_t == 0) first_t = i;
    end
    checks++;
    if (first_t != FD) begin
      failures++; $display("FAIL reset_first_tick got=%0d exp=%0d", first_t, FD);
    end
    checks++;
    if (second_t != 2 * FD) begin
      failures++; $display("FAIL reset_second_tick got=%0d exp=%0d", second_t, 2 * FD);
    end
  endtask

  task automatic test_slow_select();
    int n_evt = 0, evt_at = 0;
    int tq[$];
    key1 = 1'b1;
    for (int i = 1; i <= 140; i++) begin
      @(negedge clk);
      obs = {tick, slow, key0_evt, key1_evt};
      expv = {exp_tick, exp_slow, exp_e0, exp_e1};
      checks++;
      if (obs !== expv) begin
        failures++; $display("FAIL slowsel_model cyc=%0d got=%b exp=%b", i, obs, expv);
      end
      if (key1_evt === 1'b1) begin
        n_evt++;
        evt_at = i;
        checks++;
        if (slow !== 1'b1) begin
          failures++; $display("FAIL slowsel_same_edge got=%b exp=1", slow);
        end
      end
      if (tick === 1'b1 && evt_at != 0) tq.push_back(i);
      if (i == 20) key1 = 1'b0;
    end
    checks++;
    if (n_evt != 1) begin
      failures++; $display("FAIL slowsel_evt_count got=%0d exp=1", n_evt);
    end
    checks++;
    if (tq.size() < 2 || tq[0] != evt_at + FD * SM || tq[1] != evt_at + 2 * FD * SM) begin
      failures++;
      $display("FAIL slowsel_tick_times got=%0d,%0d exp=%0d,%0d", (tq.size() > 0) ? tq[0] : -1,
               (tq.size() > 1) ? tq[1] : -1, evt_at + FD * SM, evt_at + 2 * FD * SM);
    end
  endtask

  task automatic test_glitch();
    bit q[$];
    int tq[$];
    int hi, lo;
    repeat (5) q.push_back(1'b1);
    repeat (5) q.push_back(1'b0);
    for (int s = 0; s < 10; s++) repeat (3) q.push_back(s % 2 == 0);
    for (int g = 0; g < 6; g++) begin
      hi = $urandom_range(1, DB - 1);
      lo = $urandom_range(1, 5);
      repeat (hi) q.push_back(1'b1);
      repeat (lo) q.push_back(1'b0);
    end
    repeat (15) q.push_back(1'b0);
    for (int i = 0; i < q.size(); i++) begin
      key0 = q[i];
      @(negedge clk);
      obs = {tick, slow, key0_evt, key1_evt};
      expv = {exp_tick, exp_slow, exp_e0, exp_e1};
      checks++;
      if (obs !== expv) begin
        failures++; $display("FAIL glitch_model cyc=%0d got=%b exp=%b", i, obs, expv);
      end
      checks++;
      if ({slow, key0_evt} !== 2'b10) begin
        failures++; $display("FAIL glitch_no_evt cyc=%0d got=%b exp=10", i, {slow, key0_evt});
      end
      if (tick === 1'b1) tq.push_back(i);
    end
    key0 = 1'b0;
    checks++;
    if (tq.size() < 2) begin
      failures++; $display("FAIL glitch_tick_count got=%0d exp>=2", tq.size());
    end
    for (int k = 1; k < tq.size(); k++) begin
      checks++;
      if (tq[k] - tq[k-1] != FD * SM) begin
        failures++; $display("FAIL glitch_cadence got=%0d exp=%0d", tq[k] - tq[k-1], FD * SM);
      end
    end
  endtask

  task automatic test_simultaneous();
    int t_found = 0, evt_at = 0, tick_after = 0;
    for (int i = 1; i <= 60 && t_found == 0; i++) begin
      @(negedge clk);
      obs = {tick, slow, key0_evt, key1_evt};
      expv = {exp_tick, exp_slow, exp_e0, exp_e1};
      checks++;
      if (obs !== expv) begin
        failures++; $display("FAIL simul_wait_model cyc=%0d got=%b exp=%b", i, obs, expv);
      end
      if (tick === 1'b1) t_found = i;
    end
    checks++;
    if (t_found == 0) begin
      failures++; $display("FAIL simul_wait_tick got=none exp=tick");
    end
    // Land the debounced presses exactly on the next slow tick edge.
    for (int i = 1; i <= 29; i++) begin
      @(negedge clk);
      obs = {tick, slow, key0_evt, key1_evt};
      expv = {exp_tick, exp_slow, exp_e0, exp_e1};
      checks++;
      if (obs !== expv) begin
        failures++; $display("FAIL simul_idle_model cyc=%0d got=%b exp=%b", i, obs, expv);
      end
    end
    key0 = 1'b1;
    key1 = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      obs = {tick, slow, key0_evt, key1_evt};
      expv = {exp_tick, exp_slow, exp_e0, exp_e1};
      checks++;
      if (obs !== expv) begin
        failures++; $display("FAIL simul_model cyc=%0d got=%b exp=%b", i, obs, expv);
      end
      if (key0_evt === 1'b1 && evt_at == 0) begin
        evt_at = i;
        checks++;
        if ({key1_evt, slow, tick} !== 3'b100) begin
          failures++; $display("FAIL simul_evt_edge got=%b exp=100", {key1_evt, slow, tick});
        end
      end
      if (tick === 1'b1 && evt_at != 0 && tick_after == 0) tick_after = i;
      if (i == 12) begin
        key0 = 1'b0;
        key1 = 1'b0;
      end
    end
    checks++;
    if (evt_at != SS + DB + 1) begin
      failures++; $display("FAIL simul_evt_cycle got=%0d exp=%0d", evt_at, SS + DB + 1);
    end
    checks++;
    if (tick_after != evt_at + FD) begin
      failures++; $display("FAIL simul_next_tick got=%0d exp=%0d", tick_after, evt_at + FD);
    end
  endtask

  task automatic test_repeat_slow();
    int n_evt = 0, first_evt = 0, p2;
    int tq[$];
    p2 = $urandom_range(40, 90);
    key1 = 1'b1;
    for (int i = 1; i <= 220; i++) begin
      @(negedge clk);
      obs = {tick, slow, key0_evt, key1_evt};
      expv = {exp_tick, exp_slow, exp_e0, exp_e1};
      checks++;
      if (obs !== expv) begin
        failures++; $display("FAIL repeat_model cyc=%0d got=%b exp=%b", i, obs, expv);
      end
      if (key1_evt === 1'b1) begin
        n_evt++;
        if (first_evt == 0) first_evt = i;
      end
      if (n_evt > 0) begin
        checks++;
        if (slow !== 1'b1) begin
          failures++; $display("FAIL repeat_slow_held cyc=%0d got=%b exp=1", i, slow);
        end
      end
      if (tick === 1'b1 && n_evt > 0) tq.push_back(i);
      if (i == 12) key1 = 1'b0;
      if (i == p2) key1 = 1'b1;
      if (i == p2 + 12) key1 = 1'b0;
    end
    checks++;
    if (n_evt != 2) begin
      failures++; $display("FAIL repeat_evt_count got=%0d exp=2", n_evt);
    end
    checks++;
    if (tq.size() < 4 || tq[0] != first_evt + FD * SM) begin
      failures++;
      $display("FAIL repeat_first_tick got=%0d exp=%0d", (tq.size() > 0) ? tq[0] : -1, first_evt + FD * SM);
    end
    for (int k = 1; k < tq.size(); k++) begin
      checks++;
      if (tq[k] - tq[k-1] != FD * SM) begin
        failures++; $display("FAIL repeat_cadence got=%0d exp=%0d", tq[k] - tq[k-1], FD * SM);
      end
    end
  endtask

  task automatic test_reset_mid();
    int t_found = 0, first_t = 0, evt_at = 0;
    key1 = 1'b1;
    for (int i = 1; i <= 60 && t_found == 0; i++) begin
      @(negedge clk);
      obs = {tick, slow, key0_evt, key1_evt};
      expv = {exp_tick, exp_slow, exp_e0, exp_e1};
      checks++;
      if (obs !== expv) begin
        failures++; $display("FAIL rstmid_wait_model cyc=%0d got=%b exp=%b", i, obs, expv);
      end
      if (tick === 1'b1) t_found = i;
    end
    checks++;
    if (t_found == 0) begin
      failures++; $display("FAIL rstmid_wait_tick got=none exp=tick");
    end
    for (int i = 1; i <= FD - 3; i++) begin
      @(negedge clk);
      obs = {tick, slow, key0_evt, key1_evt};
      expv = {exp_tick, exp_slow, exp_e0, exp_e1};
      checks++;
      if (obs !== expv) begin
        failures++; $display("FAIL rstmid_pre_model cyc=%0d got=%b exp=%b", i, obs, expv);
      end
    end
    clr_n = 1'b0;
    @(negedge clk);
    obs = {tick, slow, key0_evt, key1_evt};
    checks++;
    if (obs !== 4'b0000) begin
      failures++; $display("FAIL rstmid_outputs got=%b exp=0000", obs);
    end
    clr_n = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      obs = {tick, slow, key0_evt, key1_evt};
      expv = {exp_tick, exp_slow, exp_e0, exp_e1};
      checks++;
      if (obs !== expv) begin
        failures++; $display("FAIL rstmid_model cyc=%0d got=%b exp=%b", i, obs, expv);
      end
      if (tick === 1'b1 && first_t == 0) first_t = i;
      if (key1_evt === 1'b1 && evt_at == 0) begin
        evt_at = i;
        checks++;
        if (slow !== 1'b1) begin
          failures++; $display("FAIL rstmid_slow_at_evt got=%b exp=1", slow);
        end
      end
      if (i == 30) key1 = 1'b0;
    end
    checks++;
    if (first_t != FD) begin
      failures++; $display("FAIL rstmid_first_tick got=%0d exp=%0d", first_t, FD);
    end
    checks++;
    if (evt_at != SS + DB + 1) begin
      failures++; $display("FAIL rstmid_redebounce got=%0d exp=%0d", evt_at, SS + DB + 1);
    end
  endtask

  task automatic test_random();
    int remaining = 0;
    for (int i = 1; i <= 1500; i++) begin
      @(negedge clk);
      obs = {tick, slow, key0_evt, key1_evt};
      expv = {exp_tick, exp_slow, exp_e0, exp_e1};
      checks++;
      if (obs !== expv) begin
        failures++; $display("FAIL random_model cyc=%0d got=%b exp=%b", i, obs, expv);
      end
      if (remaining == 0) begin
        key0 = 1'($urandom_range(0, 1));
        key1 = 1'($urandom_range(0, 1));
        remaining = $urandom_range(1, 20);
        clr_n = ($urandom_range(0, 49) == 0) ? 1'b0 : 1'b1;
      end else begin
        remaining--;
        clr_n = 1'b1;
      end
    end
    clr_n = 1'b1;
    key0 = 1'b0;
    key1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_slow_select();
    test_glitch();
    test_simultaneous();
    test_repeat_slow();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/scroll_tick_gen.md
Name: scroll_tick_gen

Overview:
- Upstream control stage for the 5-digit scrolling-text display.
- Takes the two raw pushbuttons and the 50 MHz board clock, synchronises and debounces the buttons, and holds the scroll-rate mode.
- Emits a single-cycle scroll-advance strobe that the display shifter consumes as a clock enable. This replaces the divided clock and the asynchronous key logic with one clock domain.

Parameters:
- FAST_DIV, 50000000, clk50 cycles between ticks in fast mode (1 Hz at 50 MHz).
- SLOW_MULT, 4, fast periods per tick in slow mode (must be >= 2).
- DEBOUNCE_CYC, 1000000, consecutive identical synchronised samples required to accept a key level change (20 ms).
- SYNC_STAGES, 2, flip-flops in each key synchroniser (>= 2).

Ports:
- clk50  in  1  board clock, 50 MHz, the only clock.
- clr_n  in  1  reset; synchronous, active-low.
- key0  in  1  raw button, asynchronous, high = pressed; selects fast mode.
- key1  in  1  raw button, asynchronous, high = pressed; selects slow mode.
- tick  out  1  one-cycle scroll-advance strobe.
- slow  out  1  current mode: 0 = fast, 1 = slow.
- key0_evt  out  1  one-cycle pulse on each debounced key0 press.
- key1_evt  out  1  one-cycle pulse on each debounced key1 press.

Behaviour:
- Reset (clr_n low at a clk50 edge):
  - All outputs 0; slow = 0 (fast mode).
  - Synchronisers, debounced levels, debounce counters, prescaler and slow counter all cleared.
- Reset mid-operation: takes effect on that edge. A partially counted debounce or prescaler period is discarded.
- Synchroniser: each key passes through SYNC_STAGES flops. All further logic uses only the last stage.
- Debounce, per key:
  - Counter clears whenever the synchronised sample equals the debounced level.
  - Otherwise the counter increments.
  - When it reaches DEBOUNCE_CYC-1 and the sample still differs, the debounced level flips and the counter clears on that edge.
  - Any glitch shorter than DEBOUNCE_CYC samples is ignored.
- Events:
  - keyN_evt is registered and high for exactly one cycle, on the edge after the debounced level rises 0->1.
  - Release (1->0) produces no event.
- Mode register:
  - key0_evt: slow <= 0.
  - key1_evt: slow <= 1.
  - Both in the same cycle: key0 wins, slow <= 0.
  - slow updates on the same edge that the event pulse is visible. An event that does not change slow has no other effect.
- Prescaler:
  - pcnt counts 0..FAST_DIV-1 and wraps to 0.
  - scnt counts 0..SLOW_MULT-1, advancing on each pcnt wrap.
- tick (registered):
  - Fast mode: high for the one cycle after each pcnt wrap. The first tick occurs exactly FAST_DIV cycles after the first edge with clr_n high; period FAST_DIV.
  - Slow mode: high only after a pcnt wrap that also wraps scnt; period FAST_DIV*SLOW_MULT.
- Mode change: on any edge where slow actually changes value, pcnt and scnt clear and tick is forced 0. The next tick comes one full new-mode period later.
- Simultaneous tick and mode change: the mode change wins and the tick is suppressed.
- Widths:
  - pcnt is $clog2(FAST_DIV) bits; scnt is $clog2(SLOW_MULT) bits; debounce counter is $clog2(DEBOUNCE_CYC) bits.
  - No counter may exceed its terminal value.

Decomposition:
- Shared package scroll_pkg:
  - Default constants CLK50_HZ, FAST_DIV_DEF, SLOW_MULT_DEF, DEBOUNCE_CYC_DEF.
  - Mode encoding constants MODE_FAST = 0, MODE_SLOW = 1, also used by the display shifter.
- One sub-module, key_debounce: synchroniser, debounce counter, rise-event pulse. Instantiated twice.

Test Plan:
(bench parameters FAST_DIV=10, SLOW_MULT=4, DEBOUNCE_CYC=8, SYNC_STAGES=2)
- Reset release, keys idle:
  - Required: tick first high on cycle 10 after release, then every 10 cycles.
  - Required: slow = 0, no key events.
- key1 held high for 20 cycles:
  - Required: exactly one key1_evt, and slow = 1 on the same edge.
  - Required: tick is 0 for the next 39 cycles, then high on cycle 40 and every 40 cycles after.
  - Release produces no event.
- key0 pulsed high for 5 cycles, plus a key0 train toggling every 3 cycles:
  - Required: no key0_evt, slow unchanged, tick cadence unchanged.
- key0 and key1 debounced presses landing on the same cycle while slow = 1:
  - Required: both events pulse, slow = 0, prescaler restarts, next tick 10 cycles later.
- key1 press while already slow = 1:
  - Required: key1_evt pulses, tick phase undisturbed, no counter clear.
- clr_n low for one cycle at pcnt = 7 in slow mode:
  - Required: slow = 0 and tick = 0 next cycle.
  - Required: first tick 10 cycles after release; a key held across reset needs a full new debounce.
